// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and widths for the shift-add multiplier.
package mult_pkg;
    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
    localparam int MULT_W = 8;
    localparam logic [2:0] LAST_STEP = 3'd7;
endpackage

// File: rtl/mult_control.sv
// mult_control: run edge detect, ADD/SHIFT sequencing and step counter for the multiplier.
module mult_control
    import mult_pkg::*;
(
    input  logic Clk,
    input  logic Reset_n,
    input  logic Run,
    input  logic ClearA_LoadB,
    output logic ld_b,
    output logic ld_s,
    output logic clr_a,
    output logic add_en,
    output logic shift_en,
    output logic sub,
    output logic busy
);
    state_t state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic run_q;
    // run_q resets high so a Run held through reset is not seen as an edge
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            run_q <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            run_q <= Run;
        end
    end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE:  if (ld_s) begin
                       state_nx = ADD;
                       cnt_nx   = '0;
                   end
            ADD:   state_nx = SHIFT;
            SHIFT: if (cnt == LAST_STEP) state_nx = DONE;
                   else begin
                       cnt_nx   = cnt + 3'd1;
                       state_nx = ADD;
                   end
            DONE:  if (!Run) state_nx = IDLE;
        endcase
    end
    assign ld_b     = state == IDLE && ClearA_LoadB;
    assign ld_s     = state == IDLE && !ClearA_LoadB && Run && !run_q;
    assign clr_a    = ld_b || ld_s;
    assign add_en   = state == ADD;
    assign shift_en = state == SHIFT;
    assign busy     = state == ADD || state == SHIFT;
    assign sub      = busy && cnt == LAST_STEP;
endmodule

// File: rtl/mult_shift_add8.sv
// mult_shift_add8: X/A/B/S registers and adder operand muxing for an 8x8 signed shift-add multiply.
module mult_shift_add8
    import mult_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Run,
    input  logic              ClearA_LoadB,
    input  logic [MULT_W-1:0] Sw,
    output logic [MULT_W-1:0] add_a,
    output logic [MULT_W-1:0] add_b,
    output logic              add_cin,
    input  logic [MULT_W-1:0] add_s,
    input  logic              add_cout,
    output logic [MULT_W-1:0] Aval,
    output logic [MULT_W-1:0] Bval,
    output logic              X,
    output logic              busy
);
    logic [MULT_W-1:0] a, b, s;
    logic ld_b, ld_s, clr_a, add_en, shift_en, sub;
    mult_control u_ctrl (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .ld_b         (ld_b),
        .ld_s         (ld_s),
        .clr_a        (clr_a),
        .add_en       (add_en),
        .shift_en     (shift_en),
        .sub          (sub),
        .busy         (busy)
    );
    // Final step subtracts S because the multiplier MSB carries negative weight
    assign add_a   = a;
    assign add_b   = sub ? ~s : s;
    assign add_cin = sub;
    assign Aval    = a;
    assign Bval    = b;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a <= '0;
            b <= '0;
            s <= '0;
            X <= 1'b0;
        end else begin
            if (ld_b) b <= Sw;
            if (ld_s) s <= Sw;
            if (clr_a) begin
                a <= '0;
                X <= 1'b0;
            end else if (add_en && b[0]) begin
                a <= add_s;
                X <= a[MULT_W-1] ^ add_b[MULT_W-1] ^ add_cout;
            end else if (shift_en) begin
                a <= {X, a[MULT_W-1:1]};
                b <= {a[0], b[MULT_W-1:1]};
            end
        end
    end
endmodule

// File: doc/mult_shift_add8.md
# mult_shift_add8

Sequential 8×8 two's-complement shift-add multiplier datapath and controller. It owns the X/A/B product registers and the multiplicand latch. Each cycle it drives the operands and carry-in of the external 8-bit ripple adder (`adder_8`) and consumes that adder's sum and carry-out. The 16-bit signed product appears in A:B, with X holding the sign extension.

## Interface
- Parameters: none; width is fixed at 8 to match `adder_8`.
- `Clk` in 1: single clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Run` in 1: start request, level input, synchronized and debounced upstream; the block acts on its rising edge.
- `ClearA_LoadB` in 1: in IDLE, clears A and X and loads B from `Sw`.
- `Sw` in 8: multiplier load value / multiplicand S.
- `add_a` out 8: adder operand a; always equals A.
- `add_b` out 8: adder operand b; equals S, or ~S on the final step.
- `add_cin` out 1: adder carry-in; 1 only on the final step.
- `add_s` in 8: adder sum.
- `add_cout` in 1: adder carry-out.
- `Aval` out 8: A register (product high byte).
- `Bval` out 8: B register (product low byte / multiplier).
- `X` out 1: sign-extension bit.
- `busy` out 1: high while a multiplication is in progress.

## Operation
- States: IDLE, ADD, SHIFT, DONE. A 3-bit step counter `cnt` runs 0..7.
- IDLE:
  - If `ClearA_LoadB`=1: A←0, X←0, B←Sw.
  - Else, on a Run rising edge (Run=1 and run_q=0): S←Sw, A←0, X←0, cnt←0, go to ADD. B is retained, so a back-to-back Run multiplies the previous low byte by the new S.
  - If `ClearA_LoadB` and a Run edge occur in the same cycle, `ClearA_LoadB` wins and the edge is discarded.
- ADD:
  - If B[0]=1: A←add_s, X←A[7]^add_b[7]^add_cout (the 9-bit sign of the sign-extended sum).
  - If B[0]=0: A and X hold.
  - Always go to SHIFT.
- SHIFT: A←{X,A[7:1]}, B←{A[0],B[7:1]}, X holds.
  - If cnt=7, go to DONE.
  - Else cnt←cnt+1 and go to ADD.
- Step 7 (the multiplier sign bit): `add_b`=~S, `add_cin`=1, so the adder computes A−S. On steps 0–6: `add_b`=S, `add_cin`=0.
- DONE: registers hold. When Run=0, go to IDLE. Holding Run high never restarts a multiplication.
- `ClearA_LoadB` and `Sw` are ignored outside IDLE. S is latched, so `Sw` changes mid-run have no effect.
- `add_a`, `add_b`, `add_cin` are combinational from registered state and are valid in every state.

## Timing
- Reset (asynchronous on `Reset_n`=0): state=IDLE, A=0x00, B=0x00, X=0, S=0x00, cnt=0, busy=0, run_q=1. Because run_q resets to 1, a Run held high through reset does not start a run.
- run_q←Run every cycle.
- Latency:
  - Edge 0: Run rise is sampled.
  - Edges 1–16: alternate ADD/SHIFT.
  - The product is final after edge 16; state is DONE at edge 16.
- `busy`=1 exactly while the state is ADD or SHIFT (16 cycles).
- Adder path: one combinational pass per ADD cycle. `add_s` must settle within one `Clk` period.
- Reset asserted mid-run: immediate return to reset values. No partial product survives.

## Structure
- Package `mult_pkg`: `state_t` enum {IDLE, ADD, SHIFT, DONE}; `localparam MULT_W=8`; `localparam LAST_STEP=3'd7`.
- Sub-module `mult_control`: FSM, `cnt`, run edge detect; outputs `ld_b`, `clr_a`, `add_en`, `shift_en`, `sub`, `busy`.
- Top level: X/A/B/S registers plus the operand muxing. `adder_8` is instantiated by the parent, not inside this block.

## Test plan
- Reset with Run=1, then release: A=B=0x00, X=0, busy=0; no run starts until Run falls and rises again.
- ClearA_LoadB with Sw=0x07, then Run with Sw=0xFD → after 16 cycles A=0xFF, B=0xEB, X=1 (−21); busy high for exactly 16 cycles.
- Load B=0x80, Run with Sw=0x80 → A=0x40, B=0x00, X=0 (+16384); the step-7 subtract path is exercised.
- Load B=0x7F, Run with Sw=0x7F → A=0x3F, B=0x01, X=0; then a second Run with Sw=0xFD (B=0x01 times −3) → A=0xFF, B=0xFD, X=1.
- Hold Run high 40 cycles, and toggle Sw and ClearA_LoadB mid-run → a single product only, unchanged by the toggles; DONE held until Run=0.
- Assert Reset_n=0 at step 4 → all registers 0 and IDLE asynchronously; a fresh run after reset gives the correct product.
